cdb_arbiter: RTL and testbench

//  Transmit side of the common data bus (CDB). Collects finished results from the N_SRC

---
 rtl/cdb_pkg.sv | 31 +++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter_rr_pick.sv | 32 +++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, source index constants, bus struct,
// and the round-robin pointer advance helper.
package cdb_pkg;

  localparam int CDB_N_SRC  = 6;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_SRC_W  = $clog2(CDB_N_SRC);

  typedef enum logic [CDB_SRC_W-1:0] {
    SRC_ADD1  = 3'd0,
    SRC_ADD2  = 3'd1,
    SRC_ADD3  = 3'd2,
    SRC_MULT1 = 3'd3,
    SRC_MULT2 = 3'd4,
    SRC_LS    = 3'd5
  } cdb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bus_t;

  // Pointer moves just past the winner, wrapping at n (need not be a power of 2).
  function automatic int unsigned rr_next(input int unsigned winner, input int unsigned n);
    return (winner == n - 1) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source handshake and CDB broadcast signals; master = execution units,
// slave = arbiter.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int N_SRC  = CDB_N_SRC,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC-1:0]        src_ready;
  logic                    cdb_valid;
  logic [DATA_W-1:0]       cdb_data;
  logic [TAG_W-1:0]        cdb_tag;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output src_valid, src_data, src_tag,
    input  src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

  modport slave (
    input  src_valid, src_data, src_tag,
    output src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping
// modulo N. Shared with RS issue selection.
module rr_pick #(
  parameter  int unsigned N  = 6,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: one-entry hold register per source, round-robin grant,
// registered broadcast. `define CDB_LS_PRIO_EN gives source N_SRC-1 (LS) absolute priority.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_SRC  = CDB_N_SRC,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int SRC_W = $clog2(N_SRC);
`ifdef CDB_LS_PRIO_EN
  localparam int unsigned LS = N_SRC - 1;
`endif

  logic [N_SRC-1:0]  hold_v;
  logic [DATA_W-1:0] hold_data [N_SRC];
  logic [TAG_W-1:0]  hold_tag  [N_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic [N_SRC-1:0]  rr_gnt;
  logic [SRC_W-1:0]  rr_idx;
  logic [N_SRC-1:0]  grant;
  logic [SRC_W-1:0]  win_idx;
  logic              ptr_adv;
  logic [N_SRC-1:0]  ready;
  logic [N_SRC-1:0]  take;

  logic              cdb_valid_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [SRC_W-1:0]  cdb_src_q;

  rr_pick #(.N(N_SRC)) u_pick (
    .req (hold_v),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  always_comb begin
    grant   = rr_gnt;
    win_idx = rr_idx;
    ptr_adv = |rr_gnt;
`ifdef CDB_LS_PRIO_EN
    // LS overrides the round-robin choice and leaves the pointer where it was.
    if (hold_v[LS]) begin
      grant     = '0;
      grant[LS] = 1'b1;
      win_idx   = SRC_W'(LS);
      ptr_adv   = 1'b0;
    end
`endif
  end

  // A slot being granted this cycle can accept its next result at the same edge.
  assign ready         = {N_SRC{~rst & ~flush}} & (~hold_v | grant);
  assign take          = bus.src_valid & ready;
  assign bus.src_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v      <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      hold_v      <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      hold_v <= take | (hold_v & ~grant);
      if (|grant) begin
        cdb_valid_q <= 1'b1;
        cdb_data_q  <= hold_data[win_idx];
        cdb_tag_q   <= hold_tag[win_idx];
        cdb_src_q   <= win_idx;
        if (ptr_adv) rr_ptr <= SRC_W'(rr_next(32'(win_idx), N_SRC));
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (take[i]) begin
        hold_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
        hold_tag[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source stimulus queues feed the handshake,
// expected broadcasts are queued in hand-computed order and checked by a monitor.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 6;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  cdb_arbiter_if #(.N_SRC(N), .DATA_W(32), .TAG_W(4)) bus ();

  cdb_arbiter #(.N_SRC(N), .DATA_W(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } item_t;

  item_t    sq [N][$];
  cdb_bus_t exp_q [$];
  cdb_bus_t mon_e;
  int       n_checks = 0;
  int       n_pass   = 0;
  logic     force_v  = 1'b1;
  logic [N-1:0] fire = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic present();
    logic [N-1:0]    v;
    logic [N*32-1:0] d;
    logic [N*4-1:0]  t;
    v = '0;
    d = '0;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (force_v) begin
        v[i] = 1'b1;
      end else if (sq[i].size() > 0) begin
        v[i]          = 1'b1;
        d[i*32 +: 32] = sq[i][0].d;
        t[i*4 +: 4]   = sq[i][0].t;
      end
    end
    bus.src_valid = v;
    bus.src_data  = d;
    bus.src_tag   = t;
  endtask

  // Source driver: retire items that handshook at this edge, then present the next.
  always @(negedge clk) fire = bus.src_valid & bus.src_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    present();
  end

  // Monitor: every broadcast must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.cdb_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_bcast: got src=%0d data=%0h tag=%0h, expected no broadcast",
                 bus.cdb_src, bus.cdb_data, bus.cdb_tag);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.cdb_src === mon_e.src && bus.cdb_data === mon_e.data && bus.cdb_tag === mon_e.tag)
          n_pass++;
        else
          $display("FAIL bcast: got src=%0d data=%0h tag=%0h expected src=%0d data=%0h tag=%0h",
                   bus.cdb_src, bus.cdb_data, bus.cdb_tag, mon_e.src, mon_e.data, mon_e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_src(input int i, input logic [31:0] d, input logic [3:0] t);
    item_t it;
    it.d = d;
    it.t = t;
    sq[i].push_back(it);
  endtask

  task automatic exp_push(input logic [2:0] s, input logic [31:0] d, input logic [3:0] t);
    cdb_bus_t e;
    e.valid = 1'b1;
    e.data  = d;
    e.tag   = t;
    e.src   = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    present();

    // Reset with all sources presenting
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(bus.src_ready), 32'h00);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'h0);
    chk("rst_cdb_data",  bus.cdb_data,       32'h0);
    chk("rst_cdb_tag",   32'(bus.cdb_tag),   32'h0);
    chk("rst_cdb_src",   32'(bus.cdb_src),   32'h0);
    tick();
    force_v = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.src_ready), 32'h3F);

    // Single ADD2 result: latency of two edges after the handshake
    tick();
    push_src(SRC_ADD2, 32'h0000_0007, 4'h3);
    exp_push(SRC_ADD2, 32'h0000_0007, 4'h3);
    tick();
    tick();
    @(negedge clk);
    chk("single_lat_k", 32'(bus.cdb_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("single_lat_k1", 32'(bus.cdb_valid), 32'h1);
    tick();
    @(negedge clk);
    chk("single_after", 32'(bus.cdb_valid), 32'h0);
    wait_drain("single_drain");

    // All six at once: six back-to-back broadcasts in order 0..5
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      push_src(i, 32'(i), 4'(i));
      exp_push(3'(i), 32'(i), 4'(i));
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      tick();
      @(negedge clk);
      chk("all6_burst", 32'(bus.cdb_valid), 32'h1);
    end
    tick();
    @(negedge clk);
    chk("all6_end", 32'(bus.cdb_valid), 32'h0);
    wait_drain("all6_drain");
    // Pointer wrapped to 0: ADD1 must beat MULT1
    push_src(SRC_MULT1, 32'h33, 4'hA);
    push_src(SRC_ADD1,  32'h30, 4'hB);
    exp_push(SRC_ADD1,  32'h30, 4'hB);
    exp_push(SRC_MULT1, 32'h33, 4'hA);
    wait_drain("rrptr_drain");

    // Backpressure: MULT1 streams three values while the others are busy
    do_reset();
    tick();
    push_src(SRC_ADD1,  32'h40,  4'h0);
    push_src(SRC_ADD2,  32'h41,  4'h1);
    push_src(SRC_ADD3,  32'h42,  4'h2);
    push_src(SRC_MULT1, 32'h430, 4'h3);
    push_src(SRC_MULT1, 32'h431, 4'h4);
    push_src(SRC_MULT1, 32'h432, 4'h5);
    push_src(SRC_MULT2, 32'h44,  4'h6);
    push_src(SRC_LS,    32'h45,  4'h7);
    exp_push(SRC_ADD1,  32'h40,  4'h0);
    exp_push(SRC_ADD2,  32'h41,  4'h1);
    exp_push(SRC_ADD3,  32'h42,  4'h2);
    exp_push(SRC_MULT1, 32'h430, 4'h3);
    exp_push(SRC_MULT2, 32'h44,  4'h6);
    exp_push(SRC_LS,    32'h45,  4'h7);
    exp_push(SRC_MULT1, 32'h431, 4'h4);
    exp_push(SRC_MULT1, 32'h432, 4'h5);
    tick();
    tick();
    @(negedge clk);
    chk("bp_ready", 32'(bus.src_ready), 32'h01);
    wait_drain("bp_drain");

    // Flush discards held results before they reach the CDB
    push_src(SRC_ADD1, 32'h50, 4'h1);
    push_src(SRC_ADD2, 32'h51, 4'h2);
    push_src(SRC_ADD3, 32'h52, 4'h3);
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(bus.src_ready), 32'h00);
    chk("flush_valid", 32'(bus.cdb_valid), 32'h0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_post_valid", 32'(bus.cdb_valid), 32'h0);
    chk("flush_post_ready", 32'(bus.src_ready), 32'h3F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_quiet", 32'(bus.cdb_valid), 32'h0);
    end
    tick();
    push_src(SRC_ADD1, 32'h55, 4'h5);
    exp_push(SRC_ADD1, 32'h55, 4'h5);
    wait_drain("flush_new_drain");

    // LS and ADD1 valid every cycle
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      push_src(SRC_ADD1, 32'h600 + 32'(k), 4'(k));
      push_src(SRC_LS,   32'h650 + 32'(k), 4'(8 + k));
    end
`ifdef CDB_LS_PRIO_EN
    for (int k = 0; k < 4; k++) exp_push(SRC_LS,   32'h650 + 32'(k), 4'(8 + k));
    for (int k = 0; k < 4; k++) exp_push(SRC_ADD1, 32'h600 + 32'(k), 4'(k));
`else
    for (int k = 0; k < 4; k++) begin
      exp_push(SRC_ADD1, 32'h600 + 32'(k), 4'(k));
      exp_push(SRC_LS,   32'h650 + 32'(k), 4'(8 + k));
    end
`endif
    wait_drain("ls_drain");

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
